// File: rtl/fcore_wb_pkg.sv
`default_nettype none
// ============================================================================
// fcore_wb_pkg : shared types and helpers for the FP ALU writeback aligner
// Rev 1.0
// ============================================================================
package fcore_wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_DEST_W = 8;

  // Unit u lives in byte u (unit 0 in the LSBs).
  localparam logic [31:0] WB_DEFAULT_LATENCY = {8'd5, 8'd5, 8'd8, 8'd1};

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic [WB_DEST_W-1:0] dest;
  } wb_entry_t;

  // True when every one of the first n latency bytes is in 1..max_lat.
  function automatic logic max_latency_check(input logic [63:0] lat,
                                             input int n,
                                             input int max_lat);
    logic ok;
    ok = 1'b1;
    for (int u = 0; u < 8; u++) begin
      if (u < n) begin
        if (int'(lat[u*8 +: 8]) == 0 || int'(lat[u*8 +: 8]) > max_lat) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fcore_wb_retire_fifo.sv
`default_nettype none
// ============================================================================
// fcore_wb_retire_fifo : register FIFO, one pop and up to N_UNITS-1 pushes/cycle
// Rev 1.0
// ============================================================================
module fcore_wb_retire_fifo
  import fcore_wb_pkg::*;
#(
  parameter int  N_UNITS    = 4,
  parameter int  FIFO_DEPTH = 4,
  parameter type entry_t    = wb_entry_t,
  localparam int C_CW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_UNITS-2:0] i_push_valid,
  input  entry_t            i_push_entry [N_UNITS-1],
  input  logic              i_pop,
  output entry_t            o_head,
  output logic [C_CW-1:0]   o_count
);

  localparam int C_PW = $clog2(FIFO_DEPTH);

  entry_t          r_mem [FIFO_DEPTH];
  logic [C_PW-1:0] r_rd;
  logic [C_PW-1:0] r_wr;
  logic [C_CW-1:0] r_count;
  logic [C_CW-1:0] w_npush;
  logic            w_pop;

  // Push lanes arrive as a contiguous prefix, so a simple count suffices.
  always_comb begin
    w_npush = '0;
    for (int k = 0; k < N_UNITS-1; k++) begin
      w_npush = w_npush + {{(C_CW-1){1'b0}}, i_push_valid[k]};
    end
  end

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      for (int k = 0; k < N_UNITS-1; k++) begin
        if (i_push_valid[k]) r_mem[r_wr + C_PW'(k)] <= i_push_entry[k];
      end
      r_wr    <= r_wr + w_npush[C_PW-1:0];
      r_rd    <= r_rd + {{(C_PW-1){1'b0}}, w_pop};
      r_count <= r_count - {{(C_CW-1){1'b0}}, w_pop} + w_npush;
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fcore_alu_writeback_aligner.sv
`default_nettype none
// ============================================================================
// fcore_alu_writeback_aligner : merges variable-latency unit results into one
// writeback stream with a retire FIFO and a per-unit issue scoreboard. Rev 1.0
// ============================================================================
module fcore_alu_writeback_aligner
  import fcore_wb_pkg::*;
#(
  parameter int                   N_UNITS        = 4,
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   REG_ADDR_WIDTH = 8,
  parameter logic [N_UNITS*8-1:0] UNIT_LATENCY   = WB_DEFAULT_LATENCY,
  parameter int                   MAX_LATENCY    = 16,
  parameter int                   FIFO_DEPTH     = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              i_issue_valid,
  input  logic [$clog2(N_UNITS)-1:0]        i_issue_unit,
  input  logic [N_UNITS-1:0]                i_unit_valid,
  input  logic [N_UNITS*DATA_WIDTH-1:0]     i_unit_data,
  input  logic [N_UNITS*REG_ADDR_WIDTH-1:0] i_unit_dest,
  input  logic                              i_clear_err,
  output logic                              o_result_valid,
  output logic [DATA_WIDTH-1:0]             o_result_data,
  output logic [REG_ADDR_WIDTH-1:0]         o_result_dest,
  output logic [$clog2(FIFO_DEPTH):0]       o_backlog,
  output logic                              o_overflow_err,
  output logic                              o_unexpected_err,
  output logic                              o_missing_err
);

  localparam int C_UW = $clog2(N_UNITS);
  localparam int C_CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [REG_ADDR_WIDTH-1:0] dest;
  } entry_t;

  if (!max_latency_check(64'(UNIT_LATENCY), N_UNITS, MAX_LATENCY)) begin : g_lat_err
    $error("UNIT_LATENCY entry outside 1..MAX_LATENCY");
  end
  if (N_UNITS < 2 || N_UNITS > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH < N_UNITS-1 ||
      (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_cfg_err
    $error("unsupported N_UNITS / FIFO_DEPTH combination");
  end

  logic [N_UNITS-1:0] w_mature;
  entry_t             w_unit_entry [N_UNITS];

  // Expectation for unit u enters at bit LAT-1 and matures when it reaches bit 0.
  for (genvar u = 0; u < N_UNITS; u++) begin : g_sb
    localparam int C_LAT = int'(UNIT_LATENCY[u*8 +: 8]);
    localparam logic [MAX_LATENCY-1:0] C_SET = MAX_LATENCY'(1) << (C_LAT-1);
    logic [MAX_LATENCY-1:0] r_exp;
    logic                   w_hit;
    assign w_hit = i_issue_valid && (i_issue_unit == C_UW'(u));
    always_ff @(posedge clock) begin
      if (reset) r_exp <= '0;
      else       r_exp <= {1'b0, r_exp[MAX_LATENCY-1:1]} | (w_hit ? C_SET : '0);
    end
    assign w_mature[u]          = r_exp[0];
    assign w_unit_entry[u].data = i_unit_data[u*DATA_WIDTH +: DATA_WIDTH];
    assign w_unit_entry[u].dest = i_unit_dest[u*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  end

  entry_t             w_head;
  logic [C_CW-1:0]    w_count;
  logic               w_pop;
  logic               w_have_out;
  entry_t             w_out;
  entry_t             w_push_entry [N_UNITS-1];
  logic [N_UNITS-2:0] w_push_valid;
  int                 w_req;
  int                 w_free;
  int                 w_acc;
  logic               w_ovf_evt;

  assign w_pop = (w_count != '0);

  // Candidate order: FIFO head, then valid units by ascending index.
  always_comb begin
    w_have_out = w_pop;
    w_out      = w_pop ? w_head : '0;
    w_req      = 0;
    for (int k = 0; k < N_UNITS-1; k++) w_push_entry[k] = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      if (i_unit_valid[u]) begin
        if (!w_have_out) begin
          w_have_out = 1'b1;
          w_out      = w_unit_entry[u];
        end else begin
          for (int k = 0; k < N_UNITS-1; k++) begin
            if (k == w_req) w_push_entry[k] = w_unit_entry[u];
          end
          w_req = w_req + 1;
        end
      end
    end
    w_free = FIFO_DEPTH - int'(w_count) + (w_pop ? 1 : 0);
    w_acc  = w_req;
    if (w_acc > N_UNITS-1) w_acc = N_UNITS-1;
    if (w_acc > w_free)    w_acc = w_free;
    w_ovf_evt = (w_req > w_acc);
    for (int k = 0; k < N_UNITS-1; k++) w_push_valid[k] = (k < w_acc);
  end

  fcore_wb_retire_fifo #(
    .N_UNITS    (N_UNITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (entry_t)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push_valid (w_push_valid),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  logic w_unexp_evt;
  logic w_miss_evt;
  assign w_unexp_evt = |(i_unit_valid & ~w_mature);
  assign w_miss_evt  = |(w_mature & ~i_unit_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      o_result_valid   <= 1'b0;
      o_result_data    <= '0;
      o_result_dest    <= '0;
      o_overflow_err   <= 1'b0;
      o_unexpected_err <= 1'b0;
      o_missing_err    <= 1'b0;
    end else begin
      o_result_valid   <= w_have_out;
      o_result_data    <= w_out.data;
      o_result_dest    <= w_out.dest;
      o_overflow_err   <= (o_overflow_err   && !i_clear_err) || w_ovf_evt;
      o_unexpected_err <= (o_unexpected_err && !i_clear_err) || w_unexp_evt;
      o_missing_err    <= (o_missing_err    && !i_clear_err) || w_miss_evt;
    end
  end

  assign o_backlog = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fcore_alu_writeback_aligner.sv
`default_nettype none
// ============================================================================
// tb_fcore_alu_writeback_aligner : directed + random bench with queue model
// Rev 1.0
// ============================================================================
module tb_fcore_alu_writeback_aligner;

  localparam int N = 4, DW = 32, AW = 8, DEPTH = 4;
  localparam logic [31:0] LATV = {8'd1, 8'd8, 8'd5, 8'd5};
  localparam int LAT [N] = '{5, 5, 8, 1};

  logic            clock = 1'b0;
  logic            reset;
  logic            i_issue_valid;
  logic [1:0]      i_issue_unit;
  logic [N-1:0]    i_unit_valid;
  logic [N*DW-1:0] i_unit_data;
  logic [N*AW-1:0] i_unit_dest;
  logic            i_clear_err;
  logic            o_result_valid;
  logic [DW-1:0]   o_result_data;
  logic [AW-1:0]   o_result_dest;
  logic [2:0]      o_backlog;
  logic            o_overflow_err, o_unexpected_err, o_missing_err;

  fcore_alu_writeback_aligner #(
    .N_UNITS(N), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW),
    .UNIT_LATENCY(LATV), .MAX_LATENCY(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .i_issue_valid(i_issue_valid), .i_issue_unit(i_issue_unit),
    .i_unit_valid(i_unit_valid), .i_unit_data(i_unit_data), .i_unit_dest(i_unit_dest),
    .i_clear_err(i_clear_err),
    .o_result_valid(o_result_valid), .o_result_data(o_result_data),
    .o_result_dest(o_result_dest), .o_backlog(o_backlog),
    .o_overflow_err(o_overflow_err), .o_unexpected_err(o_unexpected_err),
    .o_missing_err(o_missing_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: pending expectations as (unit, due cycle), FIFO as a queue.
  typedef struct { int unit; int due; } exp_t;
  typedef struct { logic [DW-1:0] data; logic [AW-1:0] dest; } ent_t;
  exp_t pend[$];
  ent_t mq[$];
  int   cyc = 0;
  logic m_valid = 0, m_unexp = 0, m_miss = 0, m_ovf = 0;
  logic [DW-1:0] m_data = 0;
  logic [AW-1:0] m_dest = 0;
  int   m_backlog = 0;

  function automatic int find_mature(input int u);
    foreach (pend[i]) if (pend[i].unit == u && pend[i].due == cyc) return i;
    return -1;
  endfunction

  task automatic model_cycle();
    ent_t cand[$];
    ent_t e;
    exp_t x;
    int   idx, acc;
    bit   eu, em, eo;
    eu = 0; em = 0; eo = 0;
    if (reset) begin
      pend.delete(); mq.delete();
      m_valid = 0; m_data = 0; m_dest = 0; m_backlog = 0;
      m_unexp = 0; m_miss = 0; m_ovf = 0;
      cyc++;
      return;
    end
    for (int u = 0; u < N; u++) begin
      idx = find_mature(u);
      if (idx >= 0) pend.delete(idx);
      if (i_unit_valid[u] && idx < 0) eu = 1;
      if (!i_unit_valid[u] && idx >= 0) em = 1;
    end
    if (i_issue_valid) begin
      x.unit = int'(i_issue_unit);
      x.due  = cyc + LAT[x.unit];
      pend.push_back(x);
    end
    if (mq.size() > 0) cand.push_back(mq.pop_front());
    for (int u = 0; u < N; u++) begin
      if (i_unit_valid[u]) begin
        e.data = i_unit_data[u*DW +: DW];
        e.dest = i_unit_dest[u*AW +: AW];
        cand.push_back(e);
      end
    end
    m_valid = 0; m_data = 0; m_dest = 0;
    if (cand.size() > 0) begin
      m_valid = 1; m_data = cand[0].data; m_dest = cand[0].dest;
    end
    acc = (cand.size() > 1) ? cand.size() - 1 : 0;
    if (acc > N-1) acc = N-1;
    if (acc > DEPTH - mq.size()) acc = DEPTH - mq.size();
    if (cand.size() - 1 > acc) eo = 1;
    for (int i = 1; i <= acc; i++) mq.push_back(cand[i]);
    m_backlog = mq.size();
    m_unexp = (m_unexp && !i_clear_err) || eu;
    m_miss  = (m_miss  && !i_clear_err) || em;
    m_ovf   = (m_ovf   && !i_clear_err) || eo;
    cyc++;
  endtask

  task automatic idle();
    reset = 0; i_issue_valid = 0; i_issue_unit = 0; i_unit_valid = 0;
    i_unit_data = {$urandom, $urandom, $urandom, $urandom};
    i_unit_dest = $urandom;
    i_clear_err = 0;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clock); #1;
    check("result_valid", o_result_valid, m_valid);
    check("result_data", o_result_data, m_data);
    check("result_dest", o_result_dest, m_dest);
    check("backlog", o_backlog, m_backlog);
    check("overflow_err", o_overflow_err, m_ovf);
    check("unexpected_err", o_unexpected_err, m_unexp);
    check("missing_err", o_missing_err, m_miss);
  endtask

  initial begin
    idle(); reset = 1;
    step(); step();
    check("reset_valid", o_result_valid, 0);
    check("reset_backlog", o_backlog, 0);

    // Single ADD on unit 0 (latency 5).
    idle(); i_issue_valid = 1; i_issue_unit = 0; step();
    idle(); repeat (4) step();
    i_unit_valid = 4'b0001; i_unit_data[31:0] = 32'h40490FDB; i_unit_dest[7:0] = 8'h03;
    step();
    check("add_valid", o_result_valid, 1);
    check("add_data", o_result_data, 32'h40490FDB);
    check("add_dest", o_result_dest, 8'h03);
    check("add_errs", {o_overflow_err, o_unexpected_err, o_missing_err}, 3'b000);

    // Collision of units 0, 1, 3.
    idle(); i_unit_valid = 4'b1011;
    i_unit_dest = {8'd4, 8'd9, 8'd2, 8'd1};
    step();
    check("coll_dest0", o_result_dest, 1); check("coll_bl0", o_backlog, 2);
    idle(); step();
    check("coll_dest1", o_result_dest, 2); check("coll_bl1", o_backlog, 1);
    idle(); step();
    check("coll_dest2", o_result_dest, 4); check("coll_bl2", o_backlog, 0);
    idle(); i_clear_err = 1; step();

    // Overflow: four back-to-back 4-unit collisions.
    for (int c = 0; c < 4; c++) begin
      idle(); i_unit_valid = 4'b1111;
      for (int u = 0; u < N; u++) i_unit_dest[u*AW +: AW] = 8'(c*16 + u);
      step();
    end
    idle(); repeat (8) step();
    check("ovf_flag", o_overflow_err, 1);
    check("ovf_drained", o_backlog, 0);
    idle(); i_clear_err = 1; step();

    // Unexpected result on unit 2.
    idle(); i_unit_valid = 4'b0100; i_unit_dest[23:16] = 8'h22; step();
    check("unexp_valid", o_result_valid, 1);
    check("unexp_dest", o_result_dest, 8'h22);
    check("unexp_flag", o_unexpected_err, 1);
    idle(); i_clear_err = 1; step();
    check("unexp_clear", o_unexpected_err, 0);

    // Missing result on unit 2 (latency 8).
    idle(); i_issue_valid = 1; i_issue_unit = 2; step();
    idle(); repeat (7) step();
    check("miss_early", o_missing_err, 0);
    step();
    check("miss_flag", o_missing_err, 1);
    idle(); i_clear_err = 1; step();

    // Reset with backlog and pending expectation.
    idle(); i_unit_valid = 4'b1111; i_issue_valid = 1; i_issue_unit = 2; step();
    check("rst_pre_bl", o_backlog, 3);
    idle(); reset = 1; step();
    check("rst_valid", o_result_valid, 0);
    check("rst_bl", o_backlog, 0);
    check("rst_errs", {o_overflow_err, o_unexpected_err, o_missing_err}, 3'b000);
    idle(); i_issue_valid = 1; i_issue_unit = 3; step();
    idle(); i_unit_valid = 4'b1000; i_unit_dest[31:24] = 8'h5A; step();
    check("rst_after_dest", o_result_dest, 8'h5A);
    idle(); repeat (10) step();
    check("rst_after_errs", {o_overflow_err, o_unexpected_err, o_missing_err}, 3'b000);

    // Randomised traffic, mostly honouring the scoreboard.
    for (int t = 0; t < 600; t++) begin
      idle();
      i_issue_valid = ($urandom_range(0, 1) == 1);
      i_issue_unit  = 2'($urandom_range(0, 3));
      for (int u = 0; u < N; u++) begin
        if (find_mature(u) >= 0) i_unit_valid[u] = ($urandom_range(0, 19) != 0);
        else                     i_unit_valid[u] = ($urandom_range(0, 29) == 0);
      end
      i_clear_err = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
